// File: rtl/lut_logic_unit.sv
// lut_logic_unit
// Programmable truth-table evaluator. An IN_W-bit index selects one OUT_W-bit
// entry from a 2**IN_W-entry table kept in flops; the selected entry is
// presented through a single registered output stage with valid/ready flow
// control. The table is loaded from INIT_TABLE on reset or restore and can be
// rewritten one entry at a time through the cfg_* port.
module lut_logic_unit #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 2,
  parameter logic [OUT_W*(2**IN_W)-1:0] INIT_TABLE = 32'h55E9_5555,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_word,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  input  logic             cfg_restore,
  output logic [CNT_W-1:0] lookup_cnt
);

  localparam int DEPTH   = 2 ** IN_W;
  localparam int TABLE_W = OUT_W * DEPTH;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. Upstream: in_ready = !out_valid || out_ready, so the single
  // output register can be refilled in the same cycle it is drained and
  // back-to-back lookups sustain one per cycle. Downstream: out_valid stays
  // high and out_word stays stable until out_ready is seen; out_valid never
  // depends combinationally on out_ready.

  // Table storage, packed so entry i sits at [OUT_W*i +: OUT_W].
  logic [TABLE_W-1:0] table_q;

  logic             out_valid_q;
  logic [OUT_W-1:0] out_word_q;
  logic [CNT_W-1:0] lookup_cnt_q;

  logic             accept;
  logic [OUT_W-1:0] rd_entry;

  // Upstream ready and the accept strobe that qualifies a lookup.
  always_comb begin
    in_ready = !out_valid_q || out_ready;
    accept   = in_valid && in_ready;
  end

  // Table read; the index covers every entry, so there is no default path.
  // The read uses the pre-edge table, so a same-edge write or restore is not
  // visible to the lookup accepted on that edge.
  always_comb begin
    rd_entry = table_q[int'(in_vec)*OUT_W +: OUT_W];
  end

  // Table update: restore takes priority over a single-entry write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      table_q <= INIT_TABLE;
    end else if (cfg_restore) begin
      table_q <= INIT_TABLE;
    end else if (cfg_we) begin
      table_q[int'(cfg_addr)*OUT_W +: OUT_W] <= cfg_data;
    end
  end

  // Output stage: load on accept, drop valid on a drain with no refill,
  // otherwise hold (stall). out_word keeps its last value after a drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_word_q  <= rd_entry;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Accepted-lookup counter; wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lookup_cnt_q <= '0;
    end else if (accept) begin
      lookup_cnt_q <= lookup_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign lookup_cnt = lookup_cnt_q;

endmodule
